// File: rtl/ray_dir_gen_if.sv
// Pose input and ray output stream of ray_dir_gen.
// The DUT uses the slave modport; the pose source / ray consumer side uses master.
interface ray_dir_gen_if #(
  parameter int unsigned SCREEN_WIDTH = 320
);
  localparam int unsigned COL_W = $clog2(SCREEN_WIDTH);

  logic             pose_valid_in;
  logic [15:0]      pos_x_in;
  logic [15:0]      pos_y_in;
  logic [15:0]      dir_x_in;
  logic [15:0]      dir_y_in;
  logic [15:0]      plane_x_in;
  logic [15:0]      plane_y_in;
  logic             frame_req_in;

  logic             ray_valid_out;
  logic             ray_ready_in;
  logic [COL_W-1:0] ray_col_out;
  logic [15:0]      ray_dir_x_out;
  logic [15:0]      ray_dir_y_out;
  logic [15:0]      pos_x_out;
  logic [15:0]      pos_y_out;
  logic [7:0]       map_x_out;
  logic [7:0]       map_y_out;
  logic             ray_last_out;
  logic             busy_out;
  logic             frame_done_out;

  modport master (
    output pose_valid_in, pos_x_in, pos_y_in, dir_x_in, dir_y_in,
           plane_x_in, plane_y_in, frame_req_in, ray_ready_in,
    input  ray_valid_out, ray_col_out, ray_dir_x_out, ray_dir_y_out,
           pos_x_out, pos_y_out, map_x_out, map_y_out, ray_last_out,
           busy_out, frame_done_out
  );

  modport slave (
    input  pose_valid_in, pos_x_in, pos_y_in, dir_x_in, dir_y_in,
           plane_x_in, plane_y_in, frame_req_in, ray_ready_in,
    output ray_valid_out, ray_col_out, ray_dir_x_out, ray_dir_y_out,
           pos_x_out, pos_y_out, map_x_out, map_y_out, ray_last_out,
           busy_out, frame_done_out
  );
endinterface

// File: rtl/ray_dir_gen.sv
// Per-frame column sweep: one ray direction (dir + plane*cameraX) per screen column,
// computed from a pose frozen at frame start, through a two-stage stallable pipeline.
module ray_dir_gen #(
  parameter int unsigned SCREEN_WIDTH = 320,
  parameter int unsigned CAM_STEP     = (2 * 65536) / SCREEN_WIDTH
) (
  input  logic          pixel_clk_in,
  input  logic          rst_in,
  ray_dir_gen_if.slave  bus
);
  localparam int unsigned COL_W = $clog2(SCREEN_WIDTH);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(SCREEN_WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_next;
  logic   start, frame_end, en, issue;

  // Shadow pose (latest sample) and working pose (frozen for the frame)
  logic signed [15:0] sh_pos_x, sh_pos_y, sh_dir_x, sh_dir_y, sh_pl_x, sh_pl_y;
  logic signed [15:0] wk_pos_x, wk_pos_y, wk_dir_x, wk_dir_y, wk_pl_x, wk_pl_y;
  logic               pending;

  // Column issue counter and Q8.16 cameraX
  logic [COL_W-1:0]   col;
  logic signed [23:0] cam;
  logic               issue_done;

  // Stage 1
  logic               s1_valid;
  logic [COL_W-1:0]   s1_col;
  logic signed [39:0] px, py;

  // Stage 2 / outputs
  logic               o_valid, o_last, o_done;
  logic [COL_W-1:0]   o_col;
  logic [15:0]        o_dir_x, o_dir_y, o_pos_x, o_pos_y;
  logic [7:0]         o_map_x, o_map_y;

  assign en    = !o_valid || bus.ray_ready_in;
  assign issue = (state == RUN) && !issue_done && en;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        if (pending || bus.pose_valid_in || bus.frame_req_in) begin
          start      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (o_valid && bus.ray_ready_in && o_last) begin
          frame_end  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      sh_pos_x <= '0; sh_pos_y <= '0; sh_dir_x <= '0;
      sh_dir_y <= '0; sh_pl_x  <= '0; sh_pl_y  <= '0;
      wk_pos_x <= '0; wk_pos_y <= '0; wk_dir_x <= '0;
      wk_dir_y <= '0; wk_pl_x  <= '0; wk_pl_y  <= '0;
      pending    <= 1'b0;
      col        <= '0;
      cam        <= '0;
      issue_done <= 1'b0;
      s1_valid   <= 1'b0;
      s1_col     <= '0;
      px         <= '0;
      py         <= '0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_done     <= 1'b0;
      o_col      <= '0;
      o_dir_x    <= '0;
      o_dir_y    <= '0;
      o_pos_x    <= '0;
      o_pos_y    <= '0;
      o_map_x    <= '0;
      o_map_y    <= '0;
    end else begin
      if (bus.pose_valid_in) begin
        sh_pos_x <= bus.pos_x_in;   sh_pos_y <= bus.pos_y_in;
        sh_dir_x <= bus.dir_x_in;   sh_dir_y <= bus.dir_y_in;
        sh_pl_x  <= bus.plane_x_in; sh_pl_y  <= bus.plane_y_in;
      end

      // A pose arriving on the start edge is consumed by that frame
      if (start) begin
        pending <= 1'b0;
        if (bus.pose_valid_in) begin
          wk_pos_x <= bus.pos_x_in;   wk_pos_y <= bus.pos_y_in;
          wk_dir_x <= bus.dir_x_in;   wk_dir_y <= bus.dir_y_in;
          wk_pl_x  <= bus.plane_x_in; wk_pl_y  <= bus.plane_y_in;
        end else begin
          wk_pos_x <= sh_pos_x; wk_pos_y <= sh_pos_y;
          wk_dir_x <= sh_dir_x; wk_dir_y <= sh_dir_y;
          wk_pl_x  <= sh_pl_x;  wk_pl_y  <= sh_pl_y;
        end
        col        <= '0;
        cam        <= 24'hFF_0000;
        issue_done <= 1'b0;
      end else if (bus.pose_valid_in) begin
        pending <= 1'b1;
      end

      if (en) begin
        s1_valid <= issue;
        if (issue) begin
          px     <= 40'(wk_pl_x) * 40'(cam);
          py     <= 40'(wk_pl_y) * 40'(cam);
          s1_col <= col;
          col    <= col + COL_W'(1);
          cam    <= cam + 24'(CAM_STEP);
          if (col == LAST_COL) issue_done <= 1'b1;
        end

        o_valid <= s1_valid;
        o_last  <= s1_valid && (s1_col == LAST_COL);
        if (s1_valid) begin
          o_col   <= s1_col;
          o_dir_x <= wk_dir_x + 16'(px >>> 16);
          o_dir_y <= wk_dir_y + 16'(py >>> 16);
          o_pos_x <= wk_pos_x;
          o_pos_y <= wk_pos_y;
          o_map_x <= wk_pos_x[15:8];
          o_map_y <= wk_pos_y[15:8];
        end
      end

      o_done <= frame_end;
    end
  end

  assign bus.ray_valid_out  = o_valid;
  assign bus.ray_col_out    = o_col;
  assign bus.ray_dir_x_out  = o_dir_x;
  assign bus.ray_dir_y_out  = o_dir_y;
  assign bus.pos_x_out      = o_pos_x;
  assign bus.pos_y_out      = o_pos_y;
  assign bus.map_x_out      = o_map_x;
  assign bus.map_y_out      = o_map_y;
  assign bus.ray_last_out   = o_last;
  assign bus.busy_out       = (state == RUN);
  assign bus.frame_done_out = o_done;
endmodule

// File: tb/tb_ray_dir_gen.sv
// Directed bench for ray_dir_gen: full frames with steady and random ready,
// pose updates mid-frame, request replay/ignore, and mid-frame reset.
module tb_ray_dir_gen;
  localparam int unsigned W    = 320;
  localparam int unsigned STEP = (2 * 65536) / W;

  typedef struct packed {
    logic [15:0] px, py, dx, dy, plx, ply;
  } pose_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  logic [15:0] got_x [W];
  logic [15:0] got_y [W];

  pose_t pa, pb, pc, pnone;

  ray_dir_gen_if #(.SCREEN_WIDTH(W)) bus ();

  ray_dir_gen #(.SCREEN_WIDTH(W), .CAM_STEP(STEP)) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: dir + ((plane * cameraX) >>> 16), cameraX = -1 + col*STEP in Q8.16
  function automatic logic [15:0] exp_dir(input logic [15:0] d, input logic [15:0] pl, input int col);
    longint cam, prod;
    cam  = -65536 + longint'(col) * longint'(STEP);
    prod = longint'($signed(pl)) * cam;
    return d + 16'(prod >>> 16);
  endfunction

  task automatic step();
    @(negedge clk);
    bus.pose_valid_in = 1'b0;
    bus.frame_req_in  = 1'b0;
  endtask

  task automatic drive_pose(input pose_t p);
    bus.pos_x_in   = p.px;  bus.pos_y_in   = p.py;
    bus.dir_x_in   = p.dx;  bus.dir_y_in   = p.dy;
    bus.plane_x_in = p.plx; bus.plane_y_in = p.ply;
    bus.pose_valid_in = 1'b1;
  endtask

  function automatic logic [63:0] out_a();
    return {5'b0, bus.ray_valid_out, bus.ray_last_out, bus.ray_col_out,
            bus.ray_dir_x_out, bus.ray_dir_y_out, bus.map_x_out, bus.map_y_out};
  endfunction

  function automatic logic [63:0] out_b();
    return {30'b0, bus.busy_out, bus.frame_done_out, bus.pos_x_out, bus.pos_y_out};
  endfunction

  // Called right after a start edge was driven: col 0 appears on the 2nd edge after start
  task automatic wait_fill();
    step();
    chk("fill_start", 64'({bus.frame_done_out, bus.ray_valid_out, bus.busy_out}), 64'(3'b001));
    step();
    chk("fill_s1", 64'({bus.ray_valid_out, bus.busy_out}), 64'(2'b01));
  endtask

  task automatic collect_frame(input pose_t e, input bit rnd,
                               input int inj1_col, input pose_t inj1,
                               input int inj2_col, input pose_t inj2,
                               input int req_col, input int stop_col);
    int col_exp = 0;
    int cyc = 0;
    int dones = 0;
    bit stalled = 1'b0;
    logic [63:0] snap_a = '0, snap_b = '0, cur_a, cur_b, exp_a;
    while (col_exp <= stop_col && cyc < 20000) begin
      step();
      cyc++;
      if (bus.frame_done_out) dones++;
      cur_a = out_a();
      cur_b = out_b();
      if (stalled) begin
        chk("stall_hold", cur_a, snap_a);
        chk("stall_hold_pos", cur_b, snap_b);
      end
      if (!rnd) chk("no_gap", 64'(bus.ray_valid_out), 64'(1));
      bus.ray_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = bus.ray_valid_out && !bus.ray_ready_in;
      snap_a  = cur_a;
      snap_b  = cur_b;
      if (bus.ray_valid_out && bus.ray_ready_in) begin
        exp_a = {5'b0, 1'b1, (col_exp == W - 1) ? 1'b1 : 1'b0, 9'(col_exp),
                 exp_dir(e.dx, e.plx, col_exp), exp_dir(e.dy, e.ply, col_exp),
                 e.px[15:8], e.py[15:8]};
        chk("beat", cur_a, exp_a);
        if (col_exp == 0) chk("pose_out", 64'({bus.pos_x_out, bus.pos_y_out}), 64'({e.px, e.py}));
        got_x[col_exp] = bus.ray_dir_x_out;
        got_y[col_exp] = bus.ray_dir_y_out;
        if (col_exp == inj1_col) drive_pose(inj1);
        if (col_exp == inj2_col) drive_pose(inj2);
        if (col_exp == req_col)  bus.frame_req_in = 1'b1;
        col_exp++;
      end
    end
    chk("frame_in_budget", 64'(cyc < 20000), 64'(1));
    chk("no_early_done", 64'(dones), 64'(0));
  endtask

  task automatic end_frame(input bit restart);
    step();
    chk("done_pulse", 64'({bus.frame_done_out, bus.ray_valid_out, bus.busy_out, bus.ray_last_out}),
        64'(4'b1000));
    if (restart) begin
      wait_fill();
    end else begin
      for (int i = 0; i < 10; i++) begin
        step();
        chk("idle_quiet", 64'({bus.frame_done_out, bus.ray_valid_out, bus.busy_out}), 64'(3'b000));
      end
    end
  endtask

  initial begin
    pa    = '{px: 16'h0C00, py: 16'h0000, dx: 16'h0000, dy: 16'h0100, plx: 16'h0000, ply: 16'h00A9};
    pb    = '{px: 16'h0C00, py: 16'h0000, dx: 16'h0100, dy: 16'h0000, plx: 16'hFF57, ply: 16'h0000};
    pc    = '{px: 16'h0305, py: 16'h0407, dx: 16'h0080, dy: 16'h0080, plx: 16'h0000, ply: 16'h0000};
    pnone = '0;
    bus.pose_valid_in = 1'b0; bus.frame_req_in = 1'b0; bus.ray_ready_in = 1'b1;
    bus.pos_x_in = '0; bus.pos_y_in = '0; bus.dir_x_in = '0;
    bus.dir_y_in = '0; bus.plane_x_in = '0; bus.plane_y_in = '0;

    rst = 1'b1;
    repeat (3) step();
    chk("reset_a", out_a(), 64'(0));
    chk("reset_b", out_b(), 64'(0));
    rst = 1'b0;
    step();
    chk("post_reset_idle", 64'({bus.busy_out, bus.ray_valid_out}), 64'(2'b00));

    // Frame 1: pose A, ready held high
    drive_pose(pa);
    wait_fill();
    collect_frame(pa, 1'b0, -1, pnone, -1, pnone, -1, W - 1);
    chk("f1_col0", 64'({got_x[0], got_y[0]}), 64'({16'h0000, 16'h0057}));
    chk("f1_col160", 64'({got_x[160], got_y[160]}), 64'({16'h0000, 16'h00FF}));
    chk("f1_col319", 64'({got_x[319], got_y[319]}), 64'({16'h0000, 16'h01A7}));
    end_frame(1'b0);

    // Frame 2: request replays shadow A with random ready; request mid-frame ignored
    bus.frame_req_in = 1'b1;
    wait_fill();
    collect_frame(pa, 1'b1, -1, pnone, -1, pnone, 40, W - 1);
    chk("f2_col160", 64'({got_x[160], got_y[160]}), 64'({16'h0000, 16'h00FF}));
    end_frame(1'b0);

    // Frame 3: pose B arrives mid-frame; frame stays A, B auto-starts next
    bus.frame_req_in = 1'b1;
    wait_fill();
    collect_frame(pa, 1'b0, 100, pb, -1, pnone, -1, W - 1);
    chk("f3_col319", 64'({got_x[319], got_y[319]}), 64'({16'h0000, 16'h01A7}));
    end_frame(1'b1);

    // Frame 4: pose B, two samples (C then A) during the frame
    collect_frame(pb, 1'b1, 50, pc, 150, pa, -1, W - 1);
    chk("f4_col0", 64'({got_x[0], got_y[0]}), 64'({16'h01A9, 16'h0000}));
    end_frame(1'b1);

    // Frame 5: exactly one frame with the second sample (A)
    collect_frame(pa, 1'b0, -1, pnone, -1, pnone, -1, W - 1);
    chk("f5_col0", 64'({got_x[0], got_y[0]}), 64'({16'h0000, 16'h0057}));
    end_frame(1'b0);

    // Frame 6: pose and request together -> one frame with incoming pose C
    drive_pose(pc);
    bus.frame_req_in = 1'b1;
    wait_fill();
    collect_frame(pc, 1'b0, -1, pnone, -1, pnone, -1, W - 1);
    chk("f6_col200", 64'({got_x[200], got_y[200]}), 64'({16'h0080, 16'h0080}));
    end_frame(1'b0);

    // Reset while column 100 is being handed over
    bus.frame_req_in = 1'b1;
    wait_fill();
    collect_frame(pc, 1'b0, -1, pnone, -1, pnone, -1, 100);
    rst = 1'b1;
    step();
    chk("mid_reset_a", out_a(), 64'(0));
    chk("mid_reset_b", out_b(), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("after_reset_idle", 64'({bus.frame_done_out, bus.ray_valid_out, bus.busy_out}), 64'(3'b000));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/ray_dir_gen.md
Name: ray_dir_gen

Overview:
- Consumer of the player-pose stream (posX/posY/dirX/dirY/planeX/planeY + valid) produced by the movement/rotation controller.
- Per frame, sweeps screen columns 0..SCREEN_WIDTH-1 and emits one ray per column: rayDir = dir + plane*cameraX, cameraX in [-1,1).
- Also emits the frame's start cell and position to the downstream DDA/wall-distance stage over a valid/ready stream.
- Latches the latest pose asynchronously to the frame sweep, so a frame always renders one consistent pose.

Parameters:
- SCREEN_WIDTH, 320, number of columns (rays) per frame.
- CAM_STEP, (2*65536)/SCREEN_WIDTH (=409), cameraX increment per column, Q8.16.

Ports:
- pixel_clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- pose_valid_in  in  1  pose sample valid (no ready; always accepted).
- pos_x_in, pos_y_in  in  16 each  position, signed Q8.8.
- dir_x_in, dir_y_in  in  16 each  direction vector, Q8.8.
- plane_x_in, plane_y_in  in  16 each  camera plane, Q8.8.
- frame_req_in  in  1  request a frame with the currently held pose.
- ray_valid_out  out  1  ray beat valid.
- ray_ready_in  in  1  downstream accepts beat.
- ray_col_out  out  $clog2(SCREEN_WIDTH)  column index.
- ray_dir_x_out, ray_dir_y_out  out  16 each  ray direction, Q8.8.
- pos_x_out, pos_y_out  out  16 each  frame pose position.
- map_x_out, map_y_out  out  8 each  pos_x[15:8], pos_y[15:8] of frame pose.
- ray_last_out  out  1  high on beat for column SCREEN_WIDTH-1.
- busy_out  out  1  high while state is RUN.
- frame_done_out  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset: state IDLE, all outputs 0, shadow pose = 0, pending = 0, column counter 0, pipeline valids 0. Reset mid-frame aborts the frame immediately; no frame_done_out.
- Shadow pose: on every pose_valid_in, all six fields are written into shadow regs and pending <= 1. Latest sample wins. Capture happens in any state.
- IDLE -> RUN when pending | pose_valid_in | frame_req_in.
- On that edge, working pose <= (pose_valid_in ? inputs : shadow), pending <= 0, col <= 0, cam <= -65536.
- Working pose is frozen for the entire frame.
- RUN: two-stage pipeline with a global advance enable en = !ray_valid_out | ray_ready_in.
- S1 (when en and col issue pending): register products px = plane_x*cam, py = plane_y*cam. This is a signed 16x24 product giving 40 bits. Also register col; then col += 1 and cam += CAM_STEP.
- S2 (when en): ray_dir_x_out = dir_x + (px >>> 16)[15:0], and likewise for y, with wrap mod 2^16 and no saturation. Also register col, last = (col == SCREEN_WIDTH-1), and pos/map from the working pose.
- Latency: column 0 is valid at the output on the 2nd edge after the start edge. Throughput is 1 ray/cycle while ray_ready_in is high.
- Stall: while ray_valid_out & !ray_ready_in, every output and pipeline register holds stable.
- After column SCREEN_WIDTH-1 is issued into S1, no further issue occurs.
- Frame end: on the handshake of the beat with ray_last_out=1, the state returns to IDLE at that edge. frame_done_out pulses high in the following cycle, and ray_valid_out drops unless another beat is in flight (none).
- A new frame can start from the IDLE cycle (the frame_done_out cycle), if pending or a request is present.
- A pose arriving during RUN only updates shadow/pending, and auto-starts the next frame.
- frame_req_in during RUN is ignored (not queued).
- pose_valid_in together with frame_req_in in IDLE starts one frame using the incoming pose; pending ends at 0.
- busy_out = (state == RUN).

Test Plan:
- Reset, then pose_valid_in with pos=(0x0C00,0), dir=(0,0x0100), plane=(0,0x00A9), ray_ready_in=1 -> 320 beats on consecutive cycles, first beat 2 cycles after start.
  - col0: dir=(0x0000,0x0057).
  - col160: dir=(0x0000,0x00FF).
  - col319: dir=(0x0000,0x01A7), with ray_last_out=1.
  - map=(12,0); frame_done_out pulses once.
- Same frame with ray_ready_in toggled pseudo-randomly -> output held stable while stalled, no column skipped or duplicated, identical values to the above.
- Mid-frame, pose_valid_in with dir=(0x0100,0), plane=(0xFF57,0) -> the current frame is unchanged.
  - The next frame auto-starts right after frame_done_out.
  - Its col0 dir=(0x01A9,0x0000).
- Two pose samples in the same frame -> exactly one following frame, using the second sample.
- frame_req_in in IDLE with no new pose -> frame replays the shadow pose; frame_req_in during RUN -> no extra frame.
- Assert rst_in at col 100 -> outputs 0 the next cycle, no frame_done_out, state IDLE, pending=0.
